bcd_conv_arbiter: RTL and testbench



---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_conv_arbiter_rr_select.sv | 38 +++
 rtl/bcd_conv_arbiter.sv | 103 ++++++++++
 tb/tb_bcd_conv_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD converter arbiter: FSM encoding and result constants.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [7:0] BCD_ERR     = 8'hEE;

endpackage

// File: rtl/bcd_conv_arbiter_rr_select.sv
// Combinational round-robin first-one finder: searches upward from ptr, wrapping modulo N.
module rr_select #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);
    localparam int IW = $clog2(N);

    logic [IW:0]   sum;
    logic [IW-1:0] k;

    // Walk offsets from farthest to nearest so the closest requester at or above ptr wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        sum    = '0;
        k      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (IW + 1)'(i);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            k = sum[IW-1:0];
            if (req[k]) begin
                onehot    = '0;
                onehot[k] = 1'b1;
                idx       = k;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one sequential binary-to-BCD converter between NUM_REQ requesters with
// round-robin arbitration and a watchdog that aborts hung conversions.
module bcd_conv_arbiter
    import bcd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 31
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*WIDTH-1:0]   bin_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic [2*BCD_DIGIT_W-1:0]   bcd_o,
    output logic                       err_o,
    output logic                       conv_start_o,
    output logic [WIDTH-1:0]           conv_bin_o,
    input  logic [2*BCD_DIGIT_W-1:0]   conv_bcd_i,
    input  logic                       conv_done_i
);
    localparam int IW = $clog2(NUM_REQ);

    state_t             state;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      idx;
    logic [WIDTH-1:0]   op_r;
    logic [7:0]         timer;

    logic [NUM_REQ-1:0] sel_onehot;
    logic [IW-1:0]      sel_idx;
    logic               sel_valid;
    logic [WIDTH-1:0]   sel_op;

    rr_select #(.N(NUM_REQ)) u_sel (
        .req    (req_i),
        .ptr    (rr_ptr),
        .onehot (sel_onehot),
        .idx    (sel_idx),
        .valid  (sel_valid)
    );

    assign sel_op     = bin_i[int'(sel_idx)*WIDTH +: WIDTH];
    assign conv_bin_o = (state == START || state == WAIT) ? op_r : '0;

    // Grant is one-hot while busy and is replayed as the done pulse on leaving RESP,
    // so done_o lands on the winner even if it has since dropped its request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            idx          <= '0;
            op_r         <= '0;
            timer        <= '0;
            gnt_o        <= '0;
            done_o       <= '0;
            bcd_o        <= '0;
            err_o        <= 1'b0;
            conv_start_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= '0;
                    err_o  <= 1'b0;
                    if (sel_valid) begin
                        idx          <= sel_idx;
                        op_r         <= sel_op;
                        gnt_o        <= sel_onehot;
                        conv_start_o <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    conv_start_o <= 1'b0;
                    timer        <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    // A converter done arriving on the last allowed cycle still beats the watchdog.
                    if (conv_done_i) begin
                        bcd_o <= conv_bcd_i;
                        err_o <= 1'b0;
                        state <= RESP;
                    end else if (timer == 8'(TIMEOUT)) begin
                        bcd_o <= BCD_ERR;
                        err_o <= 1'b1;
                        state <= RESP;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                RESP: begin
                    done_o <= gnt_o;
                    gnt_o  <= '0;
                    rr_ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: randomized transactions against an arithmetic reference model.
module tb_bcd_conv_arbiter;

    localparam int N = 4;
    localparam int W = 4;
    localparam int T = 31;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] bin;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   done_o;
    logic [7:0]     bcd_o;
    logic           err_o;
    logic           conv_start_o;
    logic [W-1:0]   conv_bin_o;
    logic [7:0]     conv_bcd;
    logic           conv_done;

    int conv_lat  = 0;
    int conv_hits = 0;
    int n_cmp     = 0;
    int n_fail    = 0;
    int ptr_m     = 0;

    bcd_conv_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(T)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .bin_i        (bin),
        .gnt_o        (gnt_o),
        .done_o       (done_o),
        .bcd_o        (bcd_o),
        .err_o        (err_o),
        .conv_start_o (conv_start_o),
        .conv_bin_o   (conv_bin_o),
        .conv_bcd_i   (conv_bcd),
        .conv_done_i  (conv_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) + (v % 10));
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // Converter model: done arrives conv_lat cycles after the start cycle; conv_lat==0 never answers.
    initial begin
        int v;
        conv_done = 1'b0;
        conv_bcd  = 8'h00;
        forever begin
            @(negedge clk);
            if (conv_start_o === 1'b1 && conv_lat > 0) begin
                v = int'(conv_bin_o);
                repeat (conv_lat) @(posedge clk);
                #1;
                conv_done = 1'b1;
                conv_bcd  = to_bcd(v);
                conv_hits++;
                @(posedge clk);
                #1;
                conv_done = 1'b0;
                conv_bcd  = 8'($urandom);
            end
        end
    end

    // Called at a negedge while the DUT is idle; that cycle is cycle 0. Returns at the done_o cycle.
    task automatic do_txn(input logic [N-1:0] r, input logic [N*W-1:0] b, input int lat,
                          input int drop_cyc, output logic [N-1:0] gnt_seen);
        int         w, exp_cyc;
        logic [W-1:0] op;
        logic [N-1:0] oh;
        logic [7:0] eb;
        logic       ee;
        bit         seen;
        req      = r;
        bin      = b;
        conv_lat = lat;
        w        = pick(r, ptr_m);
        op       = b[w*W +: W];
        oh       = N'(1) << w;
        gnt_seen = '0;
        if (lat >= 1 && lat <= T + 1) begin
            exp_cyc = lat + 3;
            eb      = to_bcd(int'(op));
            ee      = 1'b0;
        end else begin
            exp_cyc = T + 4;
            eb      = 8'hEE;
            ee      = 1'b1;
        end
        seen = 1'b0;
        for (int cyc = 1; cyc <= exp_cyc + 5; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                gnt_seen = gnt_o;
                n_cmp += 2;
                if (conv_start_o !== 1'b1) begin
                    n_fail++; $display("[TB] FAIL start_pulse got=%b want=1", conv_start_o);
                end
                if (conv_bin_o !== op) begin
                    n_fail++; $display("[TB] FAIL conv_bin got=%0d want=%0d", conv_bin_o, op);
                end
            end
            if (done_o !== '0) begin
                seen = 1'b1;
                n_cmp += 5;
                if (cyc != exp_cyc) begin
                    n_fail++; $display("[TB] FAIL done_latency got=%0d want=%0d", cyc, exp_cyc);
                end
                if (done_o !== oh) begin
                    n_fail++; $display("[TB] FAIL done_vec got=%b want=%b", done_o, oh);
                end
                if (bcd_o !== eb) begin
                    n_fail++; $display("[TB] FAIL bcd got=%h want=%h", bcd_o, eb);
                end
                if (err_o !== ee) begin
                    n_fail++; $display("[TB] FAIL err got=%b want=%b", err_o, ee);
                end
                if (gnt_o !== '0) begin
                    n_fail++; $display("[TB] FAIL gnt_after_done got=%b want=0", gnt_o);
                end
                break;
            end
            n_cmp++;
            if (gnt_o !== oh) begin
                n_fail++; $display("[TB] FAIL gnt cyc=%0d got=%b want=%b", cyc, gnt_o, oh);
            end
            if (cyc > 1) begin
                n_cmp++;
                if (conv_start_o !== 1'b0) begin
                    n_fail++; $display("[TB] FAIL start_extra cyc=%0d got=%b want=0", cyc, conv_start_o);
                end
            end
            if (cyc == drop_cyc) begin
                req = '0;
                bin = N*W'($urandom);
            end
        end
        if (!seen) begin
            n_cmp++; n_fail++;
            $display("[TB] FAIL done_missing got=none want=cycle %0d", exp_cyc);
        end
        ptr_m = (w + 1) % N;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        bin = '0;
        repeat (2) @(negedge clk);
        n_cmp += 6;
        if (gnt_o !== '0)        begin n_fail++; $display("[TB] FAIL rst_gnt got=%b want=0", gnt_o); end
        if (done_o !== '0)       begin n_fail++; $display("[TB] FAIL rst_done got=%b want=0", done_o); end
        if (bcd_o !== 8'h00)     begin n_fail++; $display("[TB] FAIL rst_bcd got=%h want=00", bcd_o); end
        if (err_o !== 1'b0)      begin n_fail++; $display("[TB] FAIL rst_err got=%b want=0", err_o); end
        if (conv_start_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_start got=%b want=0", conv_start_o); end
        if (conv_bin_o !== '0)   begin n_fail++; $display("[TB] FAIL rst_conv_bin got=%h want=0", conv_bin_o); end
        rst   = 1'b0;
        ptr_m = 0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g;
        int order [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            do_txn(4'b1111, {4'd12, 4'd9, 4'd7, 4'd3}, int'($urandom_range(1, 20)), 0, g);
            n_cmp++;
            if (g !== (N'(1) << order[i])) begin
                n_fail++; $display("[TB] FAIL rr_order step=%0d got=%b want=%b", i, g, N'(1) << order[i]);
            end
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        logic [N-1:0] g;
        do_txn(4'b0010, {8'($urandom), 4'd15, 4'($urandom)}, 12, 0, g);
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [N-1:0] g;
        do_txn(4'($urandom_range(1, 15)), N*W'($urandom), 0, 0, g);
        req = '0;
        @(negedge clk);
        n_cmp += 2;
        if (err_o !== 1'b0)  begin n_fail++; $display("[TB] FAIL err_clear got=%b want=0", err_o); end
        if (bcd_o !== 8'hEE) begin n_fail++; $display("[TB] FAIL bcd_hold got=%h want=ee", bcd_o); end
        do_txn(4'($urandom_range(1, 15)), N*W'($urandom), 9, 0, g);
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_drop_change();
        logic [N-1:0] g;
        do_txn(4'b0100, N*W'($urandom), 10, 4, g);
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_collision();
        logic [N-1:0] g;
        do_txn(4'($urandom_range(1, 15)), N*W'($urandom), T + 1, 0, g);
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g;
        bit           bad;
        int           hits0;
        do_txn(4'b0010, N*W'($urandom), 5, 0, g);
        req      = 4'b0100;
        bin      = N*W'($urandom);
        conv_lat = 7;
        hits0    = conv_hits;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        n_cmp += 4;
        if (gnt_o !== '0)          begin n_fail++; $display("[TB] FAIL midrst_gnt got=%b want=0", gnt_o); end
        if (done_o !== '0)         begin n_fail++; $display("[TB] FAIL midrst_done got=%b want=0", done_o); end
        if (conv_start_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_start got=%b want=0", conv_start_o); end
        if (conv_bin_o !== '0)     begin n_fail++; $display("[TB] FAIL midrst_conv_bin got=%h want=0", conv_bin_o); end
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done_o !== '0 || gnt_o !== '0) bad = 1'b1;
        end
        n_cmp += 2;
        if (bad) begin n_fail++; $display("[TB] FAIL stale_done got=activity want=none"); end
        if (conv_hits != hits0 + 1) begin
            n_fail++; $display("[TB] FAIL stale_injected got=%0d want=%0d", conv_hits - hits0, 1);
        end
        ptr_m = 0;
        do_txn(4'b1010, N*W'($urandom), int'($urandom_range(1, 20)), 0, g);
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [N-1:0] g;
        int           lat;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = '0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, T + 1));
            do_txn(4'($urandom_range(1, 15)), N*W'($urandom), lat, 0, g);
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_drop_change();
        test_collision();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout want=completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
